// File: rtl/envelope_pkg.sv
// Shared types and defaults for the multi-voice envelope engine.
// Building with ENVELOPE_ATTACK_EN adds the ATTACK state.
package envelope_pkg;

`ifdef ENVELOPE_ATTACK_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_PEDAL   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_ATTACK  = 3'd4
  } env_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_PEDAL   = 3'd2,
    ST_RELEASE = 3'd3
  } env_state_t;
`endif

  localparam int DEF_N_VOICES     = 4;
  localparam int DEF_VEL_W        = 7;
  localparam int DEF_HOLD_STEP    = 1;
  localparam int DEF_RELEASE_STEP = 15;
  localparam int DEF_ATTACK_STEP  = 8;
  localparam int PEDAL_BASE       = 16;

  // Pedal decay is 16 - depth, so a depth of 0 gives the fastest pedal decay.
  function automatic logic [4:0] pedal_step(input logic [3:0] depth);
    return 5'(PEDAL_BASE) - {1'b0, depth};
  endfunction

endpackage

// File: rtl/envelope_step.sv
// Combinational next-state / next-velocity for the single voice being scanned.
// ENVELOPE_ATTACK_EN adds the target input and the ATTACK ramp.
module envelope_step
  import envelope_pkg::*;
#(
  parameter int VEL_W        = DEF_VEL_W,
  parameter int HOLD_STEP    = DEF_HOLD_STEP,
  parameter int RELEASE_STEP = DEF_RELEASE_STEP,
  parameter int ATTACK_STEP  = DEF_ATTACK_STEP
) (
  input  env_state_t       i_state,
  input  logic [VEL_W-1:0] i_vel,
`ifdef ENVELOPE_ATTACK_EN
  input  logic [VEL_W-1:0] i_target,
`endif
  input  logic             i_key,
  input  logic             i_sustain,
  input  logic [3:0]       i_pedal_depth,
  output env_state_t       o_state,
  output logic [VEL_W-1:0] o_vel
);

  function automatic logic [VEL_W-1:0] sat_sub(input logic [VEL_W-1:0] a,
                                               input int unsigned step);
    if (step >= 32'(a)) return '0;
    return a - VEL_W'(step);
  endfunction

  function automatic logic [VEL_W-1:0] sat_add(input logic [VEL_W-1:0] a,
                                               input logic [VEL_W-1:0] target);
    int unsigned sum;
    sum = 32'(a) + 32'(ATTACK_STEP);
    if (sum >= 32'(target)) return target;
    return VEL_W'(sum);
  endfunction

  always_comb begin
    o_state = i_state;
    o_vel   = i_vel;
    case (i_state)
      ST_HOLD: begin
        o_vel = sat_sub(i_vel, HOLD_STEP);
        if (!i_key) o_state = i_sustain ? ST_PEDAL : ST_RELEASE;
      end
      ST_PEDAL: begin
        o_vel = sat_sub(i_vel, 32'(pedal_step(i_pedal_depth)));
        if (!i_sustain) o_state = ST_RELEASE;
      end
      ST_RELEASE: o_vel = sat_sub(i_vel, RELEASE_STEP);
`ifdef ENVELOPE_ATTACK_EN
      ST_ATTACK: begin
        if (!i_key) begin
          o_state = i_sustain ? ST_PEDAL : ST_RELEASE;
        end else begin
          o_vel = sat_add(i_vel, i_target);
          if (o_vel == i_target) o_state = ST_HOLD;
        end
      end
`endif
      default: ;
    endcase
    // A voice that has decayed to silence is always retired, whatever the transition.
    if (o_state != ST_IDLE && o_vel == '0) o_state = ST_IDLE;
  end

endmodule

// File: rtl/envelope_engine.sv
// Multi-voice envelope engine: one voice updated per clock in a scan started by envelope_pulse.
// ENVELOPE_ATTACK_EN enables the ATTACK ramp with a per-voice target register.
module envelope_engine
  import envelope_pkg::*;
#(
  parameter int N_VOICES     = DEF_N_VOICES,
  parameter int VEL_W        = DEF_VEL_W,
  parameter int HOLD_STEP    = DEF_HOLD_STEP,
  parameter int RELEASE_STEP = DEF_RELEASE_STEP,
  parameter int ATTACK_STEP  = DEF_ATTACK_STEP
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        envelope_pulse,
  input  logic                        note_on,
  input  logic [$clog2(N_VOICES)-1:0] note_voice,
  input  logic [VEL_W-1:0]            note_velocity,
  input  logic                        voice_kill,
  input  logic [N_VOICES-1:0]         key_held,
  input  logic                        sustain,
  input  logic [3:0]                  pedal_depth,
  output logic [N_VOICES*VEL_W-1:0]   voice_velocity,
  output logic [N_VOICES-1:0]         voice_active,
  output logic                        busy,
  output logic                        pulse_overrun
);

  localparam int VW = $clog2(N_VOICES);
  localparam logic [VW-1:0] LAST = VW'(N_VOICES - 1);

  env_state_t       r_state [N_VOICES];
  logic [VEL_W-1:0] r_vel   [N_VOICES];
`ifdef ENVELOPE_ATTACK_EN
  logic [VEL_W-1:0] r_target [N_VOICES];
`endif
  logic [VW-1:0]    r_scan;
  logic             r_busy;
  logic             r_pending;
  logic             r_overrun;

  env_state_t       w_next_state;
  logic [VEL_W-1:0] w_next_vel;
  logic             w_last;
  logic             w_in_range;

  assign w_last     = r_busy && (r_scan == LAST);
  assign w_in_range = int'(note_voice) < N_VOICES;

  envelope_step #(
    .VEL_W       (VEL_W),
    .HOLD_STEP   (HOLD_STEP),
    .RELEASE_STEP(RELEASE_STEP),
    .ATTACK_STEP (ATTACK_STEP)
  ) u_step (
    .i_state      (r_state[r_scan]),
    .i_vel        (r_vel[r_scan]),
`ifdef ENVELOPE_ATTACK_EN
    .i_target     (r_target[r_scan]),
`endif
    .i_key        (key_held[r_scan]),
    .i_sustain    (sustain),
    .i_pedal_depth(pedal_depth),
    .o_state      (w_next_state),
    .o_vel        (w_next_vel)
  );

  // Scan control: a pulse on the final visit chains straight into the next scan.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_busy    <= 1'b0;
      r_scan    <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (!r_busy) begin
      if (envelope_pulse) begin
        r_busy <= 1'b1;
        r_scan <= '0;
      end
    end else if (w_last) begin
      r_scan    <= '0;
      r_busy    <= r_pending | envelope_pulse;
      r_pending <= 1'b0;
      if (r_pending && envelope_pulse) r_overrun <= 1'b1;
    end else begin
      r_scan <= r_scan + 1'b1;
      if (envelope_pulse) begin
        if (r_pending) r_overrun <= 1'b1;
        else           r_pending <= 1'b1;
      end
    end
  end

  // Strobes take priority over the scan result for the same voice.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int v = 0; v < N_VOICES; v++) begin
        r_state[v] <= ST_IDLE;
        r_vel[v]   <= '0;
`ifdef ENVELOPE_ATTACK_EN
        r_target[v] <= '0;
`endif
      end
    end else begin
      for (int v = 0; v < N_VOICES; v++) begin
        if (voice_kill && w_in_range && note_voice == VW'(v)) begin
          r_state[v] <= ST_IDLE;
          r_vel[v]   <= '0;
        end else if (note_on && w_in_range && note_voice == VW'(v)) begin
          if (note_velocity == '0) begin
            r_state[v] <= ST_IDLE;
            r_vel[v]   <= '0;
          end else begin
`ifdef ENVELOPE_ATTACK_EN
            r_target[v] <= note_velocity;
            r_vel[v]    <= '0;
            r_state[v]  <= ST_ATTACK;
`else
            r_vel[v]    <= note_velocity;
            r_state[v]  <= ST_HOLD;
`endif
          end
        end else if (r_busy && r_scan == VW'(v)) begin
          r_state[v] <= w_next_state;
          r_vel[v]   <= w_next_vel;
        end
      end
    end
  end

  always_comb begin
    voice_velocity = '0;
    voice_active   = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      voice_velocity[v*VEL_W +: VEL_W] = r_vel[v];
      voice_active[v]                  = (r_state[v] != ST_IDLE);
    end
  end

  assign busy          = r_busy;
  assign pulse_overrun = r_overrun;

endmodule

// File: tb/tb_envelope_engine.sv
// Self-checking bench for envelope_engine (default build) against a scan-level behavioural model.
module tb_envelope_engine;

  localparam int N  = 4;
  localparam int VW = 7;
  localparam int HS = 1;
  localparam int RS = 15;

  localparam int M_IDLE  = 0;
  localparam int M_HOLD  = 1;
  localparam int M_PEDAL = 2;
  localparam int M_REL   = 3;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            envelope_pulse = 1'b0;
  logic            note_on = 1'b0;
  logic [1:0]      note_voice = '0;
  logic [VW-1:0]   note_velocity = '0;
  logic            voice_kill = 1'b0;
  logic [N-1:0]    key_held = '0;
  logic            sustain = 1'b0;
  logic [3:0]      pedal_depth = '0;
  logic [N*VW-1:0] voice_velocity;
  logic [N-1:0]    voice_active;
  logic            busy;
  logic            pulse_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  envelope_engine #(.N_VOICES(N), .VEL_W(VW)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .envelope_pulse(envelope_pulse),
    .note_on       (note_on),
    .note_voice    (note_voice),
    .note_velocity (note_velocity),
    .voice_kill    (voice_kill),
    .key_held      (key_held),
    .sustain       (sustain),
    .pedal_depth   (pedal_depth),
    .voice_velocity(voice_velocity),
    .voice_active  (voice_active),
    .busy          (busy),
    .pulse_overrun (pulse_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: remaining scan visits, pending flag, and per-voice velocity/state.
  typedef struct packed {
    logic [N-1:0][7:0] vel;
    logic [N-1:0][1:0] st;
    logic [31:0]       left;
    logic              pend;
    logic              ovr;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t cur);
    model_t nx;
    int v, vel, st, dec;
    nx = cur;
    if (cur.left != 0) begin
      v   = N - int'(cur.left);
      vel = int'(cur.vel[v]);
      st  = int'(cur.st[v]);
      case (st)
        M_HOLD:  dec = HS;
        M_PEDAL: dec = 16 - int'(pedal_depth);
        M_REL:   dec = RS;
        default: dec = 0;
      endcase
      vel = (vel > dec) ? vel - dec : 0;
      if (st == M_HOLD && !key_held[v]) st = sustain ? M_PEDAL : M_REL;
      else if (st == M_PEDAL && !sustain) st = M_REL;
      if (vel == 0) st = M_IDLE;
      nx.vel[v] = 8'(vel);
      nx.st[v]  = 2'(st);
    end
    if (voice_kill || note_on) begin
      v = int'(note_voice);
      if (voice_kill || note_velocity == 0) begin
        nx.vel[v] = 8'd0;
        nx.st[v]  = 2'(M_IDLE);
      end else begin
        nx.vel[v] = 8'(note_velocity);
        nx.st[v]  = 2'(M_HOLD);
      end
    end
    if (cur.left == 0) begin
      if (envelope_pulse) nx.left = N;
    end else begin
      if (envelope_pulse) begin
        if (cur.pend) nx.ovr = 1'b1;
        else          nx.pend = 1'b1;
      end
      nx.left = cur.left - 1;
      if (nx.left == 0 && nx.pend) begin
        nx.left = N;
        nx.pend = 1'b0;
      end
    end
    return nx;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) m <= '0;
    else        m <= model_next(m);
  end

  function automatic logic [N*VW-1:0] exp_vel();
    logic [N*VW-1:0] r;
    r = '0;
    for (int v = 0; v < N; v++) r[v*VW +: VW] = m.vel[v][VW-1:0];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_act();
    logic [N-1:0] r;
    for (int v = 0; v < N; v++) r[v] = (m.st[v] != 2'(M_IDLE));
    return r;
  endfunction

  function automatic int dut_vel(input int v);
    return int'(voice_velocity[v*VW +: VW]);
  endfunction

  // Driver helpers: called and return at a falling edge.
  task automatic note(input int v, input int vel);
    note_voice    = 2'(v);
    note_velocity = VW'(vel);
    note_on       = 1'b1;
    @(negedge clk);
    note_on       = 1'b0;
  endtask

  task automatic pulse_scan();
    envelope_pulse = 1'b1;
    @(negedge clk);
    envelope_pulse = 1'b0;
    repeat (N + 1) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (voice_velocity !== '0) begin
      n_fail++; $display("FAIL reset_vel: got %h expected 0", voice_velocity);
    end
    n_checks++;
    if (voice_active !== '0 || busy !== 1'b0 || pulse_overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got act=%b busy=%b ovr=%b expected 0/0/0",
                         voice_active, busy, pulse_overrun);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hold_decay();
    key_held = 4'b0001;
    note(0, 100);
    repeat (3) pulse_scan();
    n_checks++;
    if (dut_vel(0) !== 97) begin
      n_fail++; $display("FAIL hold_v0_vel: got %0d expected 97", dut_vel(0));
    end
    n_checks++;
    if (voice_active[0] !== 1'b1) begin
      n_fail++; $display("FAIL hold_v0_active: got %b expected 1", voice_active[0]);
    end
    pulse_scan();
    n_checks++;
    if (dut_vel(0) !== 96) begin
      n_fail++; $display("FAIL hold_v0_still_hold: got %0d expected 96", dut_vel(0));
    end
  endtask

  task automatic test_pedal_decay();
    key_held = 4'b0011;
    note(1, 50);
    key_held    = 4'b0001;
    sustain     = 1'b1;
    pedal_depth = 4'd12;
    pulse_scan();
    n_checks++;
    if (dut_vel(1) !== 49) begin
      n_fail++; $display("FAIL pedal_first: got %0d expected 49", dut_vel(1));
    end
    pulse_scan();
    n_checks++;
    if (dut_vel(1) !== 45) begin
      n_fail++; $display("FAIL pedal_second: got %0d expected 45", dut_vel(1));
    end
  endtask

  task automatic test_release_sat();
    int exp_v [3] = '{19, 4, 0};
    sustain  = 1'b0;
    key_held = 4'b0001;
    note(2, 20);
    for (int i = 0; i < 3; i++) begin
      pulse_scan();
      n_checks++;
      if (dut_vel(2) !== exp_v[i]) begin
        n_fail++; $display("FAIL release_step%0d: got %0d expected %0d", i, dut_vel(2), exp_v[i]);
      end
    end
    n_checks++;
    if (voice_active[2] !== 1'b0) begin
      n_fail++; $display("FAIL release_idle: got active=%b expected 0", voice_active[2]);
    end
    n_checks++;
    if (voice_velocity !== exp_vel()) begin
      n_fail++; $display("FAIL release_model: got %h expected %h", voice_velocity, exp_vel());
    end
  endtask

  task automatic test_pileup();
    int busy_cnt = 0;
    envelope_pulse = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    envelope_pulse = 1'b0;
    for (int i = 0; i < 40 && busy; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt !== 2 * N) begin
      n_fail++; $display("FAIL pileup_busy_cycles: got %0d expected %0d", busy_cnt, 2 * N);
    end
    n_checks++;
    if (pulse_overrun !== 1'b1) begin
      n_fail++; $display("FAIL pileup_overrun: got %b expected 1", pulse_overrun);
    end
    pulse_scan();
    n_checks++;
    if (pulse_overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_sticky: got %b expected 1", pulse_overrun);
    end
  endtask

  task automatic test_collision();
    key_held = 4'b1001;
    note(3, 60);
    envelope_pulse = 1'b1;
    @(negedge clk);
    envelope_pulse = 1'b0;
    repeat (3) @(negedge clk);
    // The scan is visiting voice 3 during this cycle.
    note(3, 90);
    n_checks++;
    if (dut_vel(3) !== 90 || voice_active[3] !== 1'b1) begin
      n_fail++; $display("FAIL collide_note: got vel=%0d act=%b expected 90/1", dut_vel(3), voice_active[3]);
    end
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    pulse_scan();
    n_checks++;
    if (dut_vel(3) !== 89) begin
      n_fail++; $display("FAIL collide_hold: got %0d expected 89", dut_vel(3));
    end
    voice_kill    = 1'b1;
    note_on       = 1'b1;
    note_voice    = 2'd3;
    note_velocity = 7'd77;
    @(negedge clk);
    voice_kill = 1'b0;
    note_on    = 1'b0;
    n_checks++;
    if (dut_vel(3) !== 0 || voice_active[3] !== 1'b0) begin
      n_fail++; $display("FAIL kill_wins: got vel=%0d act=%b expected 0/0", dut_vel(3), voice_active[3]);
    end
  endtask

  task automatic test_reset_midscan();
    key_held = 4'b0011;
    note(0, 30);
    note(1, 30);
    envelope_pulse = 1'b1;
    @(negedge clk);
    envelope_pulse = 1'b0;
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    n_checks++;
    if (voice_velocity !== '0 || voice_active !== '0 || busy !== 1'b0 || pulse_overrun !== 1'b0) begin
      n_fail++; $display("FAIL midscan_reset: got vel=%h act=%b busy=%b ovr=%b expected all 0",
                         voice_velocity, voice_active, busy, pulse_overrun);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    note(0, 30);
    note(1, 30);
    envelope_pulse = 1'b1;
    @(negedge clk);
    envelope_pulse = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut_vel(0) !== 29 || dut_vel(1) !== 30 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_at_v0: got v0=%0d v1=%0d busy=%b expected 29/30/1",
                         dut_vel(0), dut_vel(1), busy);
    end
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 600; c++) begin
      n_checks++;
      if (voice_velocity !== exp_vel() || voice_active !== exp_act() ||
          busy !== (m.left != 0) || pulse_overrun !== m.ovr) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random_c%0d: got vel=%h act=%b busy=%b ovr=%b expected vel=%h act=%b busy=%b ovr=%b",
                   c, voice_velocity, voice_active, busy, pulse_overrun,
                   exp_vel(), exp_act(), (m.left != 0), m.ovr);
        bad++;
      end
      envelope_pulse = ($urandom_range(0, 3) == 0);
      note_on        = ($urandom_range(0, 5) == 0);
      voice_kill     = ($urandom_range(0, 11) == 0);
      note_voice     = 2'($urandom_range(0, N - 1));
      note_velocity  = VW'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) key_held = N'($urandom);
      if ($urandom_range(0, 9) == 0) sustain = ~sustain;
      pedal_depth    = 4'($urandom);
      @(negedge clk);
    end
    envelope_pulse = 1'b0;
    note_on        = 1'b0;
    voice_kill     = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold_decay();
    test_pedal_decay();
    test_release_sat();
    test_pileup();
    test_collision();
    test_reset_midscan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
